// File: rtl/regfile_read_port_if.sv
// Operand bus between decode/retire (master) and the register file read port (slave).
// Carries read requests, the retire-side write and the registered operand returns.
interface regfile_read_port_if #(
    parameter int n  = 32,
    parameter int AW = 5
);
    logic          re;
    logic          stall;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          w;
    logic [AW-1:0] rd;
    logic [n-1:0]  i;
    logic [n-1:0]  o1;
    logic [n-1:0]  o2;
    logic          rvalid;

    modport master (
        output re, stall, rs1, rs2, w, rd, i,
        input  o1, o2, rvalid
    );

    modport slave (
        input  re, stall, rs1, rs2, w, rd, i,
        output o1, o2, rvalid
    );
endinterface

// File: rtl/regfile_read_port.sv
// Dual-read, single-write integer register file with registered reads,
// same-edge write forwarding, stall hold and a read-valid strobe. x0 reads as zero.
module regfile_read_port #(
    parameter int n    = 32,
    parameter int REGS = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_read_port_if.slave   rf
);

    logic [n-1:0] regs_q [REGS];
    logic [n-1:0] o1_q, o1_d;
    logic [n-1:0] o2_q, o2_d;
    logic         rvalid_q, rvalid_d;

    logic         wr_en;
    logic [n-1:0] val1, val2;

    assign wr_en = rf.w && (rf.rd != AW'(0));

    // Forward the retiring write so a same-edge read sees the new value.
    always_comb begin
        val1 = '0;
        val2 = '0;
        if (rf.rs1 != AW'(0)) begin
            val1 = (wr_en && (rf.rd == rf.rs1)) ? rf.i : regs_q[rf.rs1];
        end
        if (rf.rs2 != AW'(0)) begin
            val2 = (wr_en && (rf.rd == rf.rs2)) ? rf.i : regs_q[rf.rs2];
        end
    end

    always_comb begin
        o1_d     = o1_q;
        o2_d     = o2_q;
        rvalid_d = rvalid_q;
        if (!rf.stall) begin
            rvalid_d = rf.re;
            if (rf.re) begin
                o1_d = val1;
                o2_d = val2;
            end
        end
    end

    // Flop-based storage so the async clear reaches every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rf.rd] <= rf.i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o1_q     <= '0;
            o2_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            o1_q     <= o1_d;
            o2_q     <= o2_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rf.o1     = o1_q;
    assign rf.o2     = o2_q;
    assign rf.rvalid = rvalid_q;

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Dual-read, single-write integer register file for the arRISCado core.
- Sits between decode and execute. Decode presents source register addresses; execute receives operand values one clock later.
- Write side is the retire path, using the same write-enable semantics as the team's single Register element.
- Provides registered reads with same-edge write forwarding, stall hold, and a read-valid strobe.

Parameters:
- n, 32, data width of each register in bits.
- REGS, 32, number of architectural registers; must be a power of two and at least 2.
- AW, 5, address width; equals log2(REGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- re  input  1  read request: capture operands on this edge.
- stall  input  1  hold read outputs and rvalid unchanged; overrides re.
- rs1  input  AW  source register 1 address.
- rs2  input  AW  source register 2 address.
- w  input  1  write enable.
- rd  input  AW  destination register address.
- i  input  n  write data.
- o1  output  n  registered operand 1.
- o2  output  n  registered operand 2.
- rvalid  output  1  o1/o2 hold data captured by an accepted read.

Behaviour:
- Reset:
  - rst_n low forces all REGS entries, o1, o2 and rvalid to 0 immediately, without waiting for clk.
  - Release is synchronous to the next rising clk edge; the first update happens on the first rising edge with rst_n high.
- Register 0:
  - Hardwired zero; a write with rd=0 is ignored.
  - Any read of address 0 returns 0, even when w=1, rd=0 and i is non-zero on the same edge.
- Write:
  - On a rising edge with w=1 and rd!=0, entry[rd] <= i.
  - The new value is visible to array reads from the following cycle.
- Read, one-cycle latency:
  - On a rising edge with re=1 and stall=0: o1 <= value(rs1), o2 <= value(rs2), rvalid <= 1.
  - On a rising edge with re=0 and stall=0: rvalid <= 0; o1/o2 hold their previous values.
  - On a rising edge with stall=1: o1, o2 and rvalid all hold, regardless of re, rs1 and rs2.
  - Writes still take effect while stalled.
- Forwarding (simultaneous read and write):
  - value(x) = i when w=1, rd=x and x!=0.
  - Otherwise value(x) = entry[x].
  - A read of the register being written on the same edge therefore returns the new data, not the stale entry.
  - rs1=rs2 is legal; both outputs receive the identical value.
- No other hazards: back-to-back reads, writes to any register every cycle, and repeated writes to the same register are all legal.
  - For repeated writes, the last write wins.
- Reset mid-operation:
  - An rst_n assertion coincident with a write or read discards it.
  - All state is zero afterwards.
- Arithmetic and width:
  - No arithmetic.
  - Addresses are used modulo REGS, i.e. the full AW bits.
  - i is stored exactly n bits wide.
- Implementation constraint: storage must be flip-flop based so the asynchronous clear applies to every entry.

Test Plan:
- Reset: hold rst_n=0 with clk toggling, then release; read rs1=5, rs2=31 with re=1 -> one edge later o1=0, o2=0, rvalid=1.
- Write then read: w=1, rd=7, i=32'hDEADBEEF on edge 1; re=1, rs1=7, rs2=0 on edge 2 -> after edge 2, o1=32'hDEADBEEF, o2=0, rvalid=1.
- Forwarding: entry[3]=32'h11 already; on one edge w=1, rd=3, i=32'h22 and re=1, rs1=3, rs2=3 -> o1=o2=32'h22. A following read of x3 also returns 32'h22.
- x0 immunity: w=1, rd=0, i=32'hFFFFFFFF with re=1, rs1=0 -> o1=0. A later read of x0 -> 0.
- Stall: capture o1=32'h22, then assert stall=1 for 3 edges while changing rs1 and writing rd=3, i=32'h33 -> o1 stays 32'h22, rvalid stays 1. After stall drops with re=1, rs1=3 -> o1=32'h33.
- Async reset mid-stream: after several writes, pulse rst_n low between clock edges -> o1, o2, rvalid go 0 immediately. Subsequent reads of previously written registers return 0.
